// File: rtl/sme_job_arbiter.sv
// Shares one SME string-matching engine between NREQ requesters.
// Each requester streams a string or pattern segment into a local buffer. The
// segment is then burst into the SME one char per cycle, and the result goes
// back to the requester that owns the job.
module sme_job_arbiter #(
    parameter int unsigned NREQ        = 2,
    parameter int unsigned STR_MAX     = 32,
    parameter int unsigned PAT_MAX     = 8,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [8*NREQ-1:0]    req_data,
    input  logic [NREQ-1:0]      req_kind,
    input  logic [NREQ-1:0]      req_last,
    output logic [NREQ-1:0]      rsp_valid,
    output logic                 rsp_match,
    output logic [4:0]           rsp_index,
    output logic [1:0]           rsp_err,
    output logic [7:0]           sme_chardata,
    output logic                 sme_isstring,
    output logic                 sme_ispattern,
    input  logic                 sme_valid,
    input  logic                 sme_match,
    input  logic [4:0]           sme_match_index
);

    localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned LW = $clog2(STR_MAX + 1);
    localparam int unsigned AW = (STR_MAX > 1) ? $clog2(STR_MAX) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_NOSTR   = 2'd1;
    localparam logic [1:0] ERR_LEN     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_CHECK,
        S_BURST,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic              kind_q, kind_d;
    logic [LW-1:0]     len_q, len_d;
    logic              ovf_q, ovf_d;
    logic [LW-1:0]     k_q, k_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [GW-1:0]     rr_q, rr_d;
    logic              own_vld_q, own_vld_d;
    logic [GW-1:0]     own_q, own_d;

    logic [NREQ-1:0]   req_ready_d;
    logic [NREQ-1:0]   rsp_valid_d;
    logic              rsp_match_d;
    logic [4:0]        rsp_index_d;
    logic [1:0]        rsp_err_d;
    logic [7:0]        sme_chardata_d;
    logic              sme_isstring_d;
    logic              sme_ispattern_d;

    logic [7:0]        buf_mem [STR_MAX];
    logic              buf_we;
    logic [AW-1:0]     wr_idx;
    logic [AW-1:0]     rd_idx;

    logic              cur_valid;
    logic              cur_last;
    logic [7:0]        cur_data;
    logic              pick_found;
    logic [GW-1:0]     pick_idx;
    logic              found_hi;
    logic [GW-1:0]     idx_hi;
    logic [GW-1:0]     idx_lo;
    logic [LW-1:0]     seg_max;
    logic [LW-1:0]     k_next;
    logic              accept;

    // One-hot decode of a requester index
    function automatic logic [NREQ-1:0] onehot(input logic [GW-1:0] g);
        logic [NREQ-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (GW'(i) == g) v[i] = 1'b1;
        end
        return v;
    endfunction

    // Select the granted requester's byte, valid and last
    always_comb begin
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        cur_data  = 8'd0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (GW'(i) == grant_q) begin
                cur_valid = req_valid[i];
                cur_last  = req_last[i];
                cur_data  = req_data[i*8 +: 8];
            end
        end
    end

    // Round-robin: lowest valid index at/after rr, else lowest valid overall
    always_comb begin
        pick_found = 1'b0;
        found_hi   = 1'b0;
        idx_hi     = '0;
        idx_lo     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (req_valid[i]) begin
                if (!pick_found) begin
                    pick_found = 1'b1;
                    idx_lo     = GW'(i);
                end
                if (!found_hi && (GW'(i) >= rr_q)) begin
                    found_hi = 1'b1;
                    idx_hi   = GW'(i);
                end
            end
        end
        pick_idx = found_hi ? idx_hi : idx_lo;
    end

    assign seg_max = kind_q ? LW'(PAT_MAX) : LW'(STR_MAX);
    assign k_next  = k_q + LW'(1);
    assign accept  = cur_valid && (|req_ready);
    assign wr_idx  = AW'(len_q);
    assign rd_idx  = (state_q == S_BURST) ? AW'(k_next) : '0;

    // Next-state and next-output logic
    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        kind_d          = kind_q;
        len_d           = len_q;
        ovf_d           = ovf_q;
        k_d             = k_q;
        cnt_d           = cnt_q;
        rr_d            = rr_q;
        own_vld_d       = own_vld_q;
        own_d           = own_q;
        req_ready_d     = '0;
        rsp_valid_d     = '0;
        rsp_match_d     = 1'b0;
        rsp_index_d     = 5'd0;
        rsp_err_d       = ERR_OK;
        sme_chardata_d  = sme_chardata;
        sme_isstring_d  = 1'b0;
        sme_ispattern_d = 1'b0;
        buf_we          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_d     = pick_idx;
                    kind_d      = req_kind[pick_idx];
                    req_ready_d = onehot(pick_idx);
                    state_d     = S_COLLECT;
                end
            end

            S_COLLECT: begin
                req_ready_d = onehot(grant_q);
                if (accept) begin
                    if (len_q < seg_max) begin
                        buf_we = 1'b1;
                        len_d  = len_q + LW'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (cur_last) begin
                        req_ready_d = '0;
                        state_d     = S_CHECK;
                    end
                end
            end

            S_CHECK: begin
                if (ovf_q) begin
                    rsp_valid_d = onehot(grant_q);
                    rsp_err_d   = ERR_LEN;
                    state_d     = S_RESP;
                end else if (kind_q && (!own_vld_q || (own_q != grant_q))) begin
                    rsp_valid_d = onehot(grant_q);
                    rsp_err_d   = ERR_NOSTR;
                    state_d     = S_RESP;
                end else begin
                    k_d             = '0;
                    sme_chardata_d  = buf_mem[rd_idx];
                    sme_isstring_d  = !kind_q;
                    sme_ispattern_d = kind_q;
                    state_d         = S_BURST;
                end
            end

            S_BURST: begin
                if (k_next < len_q) begin
                    k_d             = k_next;
                    sme_chardata_d  = buf_mem[rd_idx];
                    sme_isstring_d  = !kind_q;
                    sme_ispattern_d = kind_q;
                end else if (!kind_q) begin
                    own_vld_d   = 1'b1;
                    own_d       = grant_q;
                    rsp_valid_d = onehot(grant_q);
                    state_d     = S_RESP;
                end else begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (sme_valid) begin
                    rsp_valid_d = onehot(grant_q);
                    rsp_match_d = sme_match;
                    rsp_index_d = sme_match_index;
                    state_d     = S_RESP;
                end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    rsp_valid_d = onehot(grant_q);
                    rsp_err_d   = ERR_TIMEOUT;
                    own_vld_d   = 1'b0;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_RESP: begin
                rr_d    = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + GW'(1);
                len_d   = '0;
                ovf_d   = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Segment buffer write port
    always_ff @(posedge clk) begin
        if (buf_we) buf_mem[wr_idx] <= cur_data;
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            grant_q       <= '0;
            kind_q        <= 1'b0;
            len_q         <= '0;
            ovf_q         <= 1'b0;
            k_q           <= '0;
            cnt_q         <= '0;
            rr_q          <= '0;
            own_vld_q     <= 1'b0;
            own_q         <= '0;
            req_ready     <= '0;
            rsp_valid     <= '0;
            rsp_match     <= 1'b0;
            rsp_index     <= 5'd0;
            rsp_err       <= 2'd0;
            sme_chardata  <= 8'd0;
            sme_isstring  <= 1'b0;
            sme_ispattern <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            kind_q        <= kind_d;
            len_q         <= len_d;
            ovf_q         <= ovf_d;
            k_q           <= k_d;
            cnt_q         <= cnt_d;
            rr_q          <= rr_d;
            own_vld_q     <= own_vld_d;
            own_q         <= own_d;
            req_ready     <= req_ready_d;
            rsp_valid     <= rsp_valid_d;
            rsp_match     <= rsp_match_d;
            rsp_index     <= rsp_index_d;
            rsp_err       <= rsp_err_d;
            sme_chardata  <= sme_chardata_d;
            sme_isstring  <= sme_isstring_d;
            sme_ispattern <= sme_ispattern_d;
        end
    end

endmodule

// File: tb/tb_sme_job_arbiter.sv
// Randomised scoreboard bench for sme_job_arbiter with an SME behavioural model.
module tb_sme_job_arbiter;

    localparam int NREQ    = 2;
    localparam int STR_MAX = 32;
    localparam int PAT_MAX = 8;
    localparam int TIMEOUT = 1024;

    typedef byte unsigned bq_t[$];
    typedef struct {
        int req;
        int match;
        int index;
        int err;
    } exp_t;

    logic                 clk;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [8*NREQ-1:0]    req_data;
    logic [NREQ-1:0]      req_kind;
    logic [NREQ-1:0]      req_last;
    logic [NREQ-1:0]      rsp_valid;
    logic                 rsp_match;
    logic [4:0]           rsp_index;
    logic [1:0]           rsp_err;
    logic [7:0]           sme_chardata;
    logic                 sme_isstring;
    logic                 sme_ispattern;
    logic                 sme_valid;
    logic                 sme_match;
    logic [4:0]           sme_match_index;

    logic       d_valid [NREQ];
    logic [7:0] d_data  [NREQ];
    logic       d_kind  [NREQ];
    logic       d_last  [NREQ];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // scoreboard queues
    exp_t exp_rsp[$];
    int   exp_blen[$];
    int   exp_bkind[$];
    byte unsigned exp_bdata[$];

    // reference model state
    bq_t m_str;
    int  m_owner = -1;
    int  m_rr = 0;

    // monitor bookkeeping
    int  rsp_cyc = 0;
    int  first_strobe_cyc = 0;
    int  last_strobe_cyc = 0;
    bit  mute = 0;
    int  reset_gen = 0;

    sme_job_arbiter #(
        .NREQ(NREQ), .STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX), .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .req_kind(req_kind), .req_last(req_last),
        .rsp_valid(rsp_valid), .rsp_match(rsp_match), .rsp_index(rsp_index),
        .rsp_err(rsp_err),
        .sme_chardata(sme_chardata), .sme_isstring(sme_isstring),
        .sme_ispattern(sme_ispattern),
        .sme_valid(sme_valid), .sme_match(sme_match), .sme_match_index(sme_match_index)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        req_valid = '0;
        req_data  = '0;
        req_kind  = '0;
        req_last  = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]       = d_valid[i];
            req_data[i*8 +: 8] = d_data[i];
            req_kind[i]        = d_kind[i];
            req_last[i]        = d_last[i];
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic bq_t s2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // first occurrence of p inside s
    function automatic void find(input bq_t s, input bq_t p, output int m, output int idx);
        bit hit;
        m = 0;
        idx = 0;
        for (int i = 0; i + p.size() <= s.size(); i++) begin
            hit = 1;
            for (int j = 0; j < p.size(); j++) if (s[i+j] != p[j]) hit = 0;
            if (hit) begin
                m = 1;
                idx = i;
                return;
            end
        end
    endfunction

    function automatic void push_burst(input int kind, input bq_t q);
        exp_blen.push_back(q.size());
        exp_bkind.push_back(kind);
        foreach (q[i]) exp_bdata.push_back(q[i]);
    endfunction

    // Reference model: job rules applied to one served segment
    function automatic void predict(input int r, input int kind, input bq_t q, input bit no_answer);
        exp_t e;
        int m, idx;
        e.req = r; e.match = 0; e.index = 0; e.err = 0;
        if (kind == 0) begin
            if (q.size() > STR_MAX) e.err = 2;
            else begin
                push_burst(0, q);
                m_str = q;
                m_owner = r;
            end
        end else begin
            if (q.size() > PAT_MAX) e.err = 2;
            else if (m_owner != r) e.err = 1;
            else begin
                push_burst(1, q);
                if (no_answer) begin
                    e.err = 3;
                    m_owner = -1;
                end else begin
                    find(m_str, q, m, idx);
                    e.match = m;
                    e.index = idx;
                end
            end
        end
        exp_rsp.push_back(e);
        m_rr = (r + 1) % NREQ;
    endfunction

    // Stream one segment on requester r; called right after a negedge
    task automatic drive_seg(input int r, input int kind, input bq_t q, input bit gaps,
                             output int t_last, output bit ok);
        int w;
        ok = 1;
        t_last = -1;
        d_kind[r] = kind[0];
        for (int i = 0; i < q.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                d_valid[r] = 0;
                @(negedge clk);
            end
            d_valid[r] = 1;
            d_data[r]  = q[i];
            d_last[r]  = (i == q.size() - 1);
            w = 0;
            while (!req_ready[r]) begin
                @(negedge clk);
                w++;
                if (w > 3000) begin
                    chk("drive_ready_timeout", w, 0);
                    ok = 0;
                    d_valid[r] = 0;
                    d_last[r] = 0;
                    return;
                end
            end
            if (i == q.size() - 1) t_last = cyc;
            @(negedge clk);
        end
        d_valid[r] = 0;
        d_last[r]  = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_rsp.size() != 0 || exp_blen.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", exp_rsp.size() + exp_blen.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic job(input int r, input int kind, input bq_t q, input bit gaps, output int t);
        bit ok;
        predict(r, kind, q, mute);
        drive_seg(r, kind, q, gaps, t, ok);
        drain();
    endtask

    // Burst monitor plus SME model: records strobe runs, answers patterns
    initial begin : sme_model
        bq_t run, rx_str;
        int run_kind, seen_gen, bl, bk, nbad, m, idx;
        bit pend;
        int pend_dly, pend_m, pend_i;
        byte unsigned eb;
        pend = 0; pend_dly = 0; pend_m = 0; pend_i = 0;
        run_kind = 0; seen_gen = 0;
        sme_valid = 0; sme_match = 0; sme_match_index = 0;
        forever begin
            @(negedge clk);
            sme_valid = 0;
            if (pend) begin
                if (pend_dly == 0) begin
                    sme_valid = 1;
                    sme_match = pend_m[0];
                    sme_match_index = 5'(pend_i);
                    pend = 0;
                end else pend_dly--;
            end
            if (sme_isstring || sme_ispattern) begin
                if (run.size() == 0) first_strobe_cyc = cyc;
                last_strobe_cyc = cyc;
                run.push_back(sme_chardata);
                run_kind = sme_ispattern ? 1 : 0;
            end else if (seen_gen != reset_gen) begin
                run.delete();
                pend = 0;
                seen_gen = reset_gen;
            end else if (run.size() != 0) begin
                if (exp_blen.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_burst actual_len=%0d kind=%0d required=none", run.size(), run_kind);
                end else begin
                    bl = exp_blen.pop_front();
                    bk = exp_bkind.pop_front();
                    chk("burst_len", run.size(), bl);
                    chk("burst_kind", run_kind, bk);
                    nbad = 0;
                    for (int i = 0; i < bl; i++) begin
                        eb = exp_bdata.pop_front();
                        if (i >= run.size() || run[i] != eb) nbad++;
                    end
                    chk("burst_data_bad_chars", nbad, 0);
                end
                if (run_kind == 1) begin
                    if (!mute) begin
                        find(rx_str, run, m, idx);
                        pend = 1;
                        pend_m = m;
                        pend_i = idx;
                        pend_dly = $urandom_range(0, 12);
                    end
                end else begin
                    rx_str = run;
                end
                run.delete();
            end
        end
    end

    // Response monitor: pops the scoreboard on every rsp pulse
    initial begin : rsp_monitor
        exp_t e;
        int r;
        forever begin
            @(negedge clk);
            if (rsp_valid != '0) begin
                rsp_cyc = cyc;
                chk("rsp_onehot", $countones(rsp_valid), 1);
                r = -1;
                for (int i = NREQ - 1; i >= 0; i--) if (rsp_valid[i]) r = i;
                if (exp_rsp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp actual_req=%0d err=%0d required=none", r, rsp_err);
                end else begin
                    e = exp_rsp.pop_front();
                    chk("rsp_req", r, e.req);
                    chk("rsp_err", int'(rsp_err), e.err);
                    chk("rsp_match", int'(rsp_match), e.match);
                    chk("rsp_index", int'(rsp_index), e.index);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int t, t2, len, pos;
        bit ok;
        bq_t q, q2;
        int r, kind;
        for (int i = 0; i < NREQ; i++) begin
            d_valid[i] = 0; d_data[i] = 0; d_kind[i] = 0; d_last[i] = 0;
        end
        reset = 1;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", int'(req_ready), 0);
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_rsp_err", int'(rsp_err), 0);
        chk("reset_strobes", int'({sme_isstring, sme_ispattern}), 0);
        chk("reset_chardata", int'(sme_chardata), 0);
        reset = 0;
        @(negedge clk);

        // two requesters in the same cycle, rr starts at 0
        q = s2q("hello");
        q2 = s2q("world");
        if (m_rr == 0) begin
            predict(0, 0, q, 0);
            predict(1, 0, q2, 0);
        end else begin
            predict(1, 0, q2, 0);
            predict(0, 0, q, 0);
        end
        fork
            begin int ta; bit oa; drive_seg(0, 0, q, 0, ta, oa); end
            begin int tb; bit ob; drive_seg(1, 0, q2, 0, tb, ob); end
        join
        drain();

        // string then matching pattern, with latency checks on the string
        job(0, 0, s2q("abcde"), 0, t);
        chk("str_rsp_latency", rsp_cyc - t, 5 + 2);
        chk("str_burst_start", first_strobe_cyc - t, 2);
        chk("str_burst_end", last_strobe_cyc - t, 5 + 1);
        job(0, 1, s2q("cd"), 0, t);

        // pattern from a requester that does not own the string
        job(1, 1, s2q("ab"), 0, t);

        // oversize segments
        predict(0, 0, s2q("abcdefghijklmnopqrstuvwxyz0123456"), 0);
        drive_seg(0, 0, s2q("abcdefghijklmnopqrstuvwxyz0123456"), 1, t, ok);
        chk("overflow_all_bytes_accepted", int'(ok), 1);
        drain();
        job(0, 1, s2q("abcdefghi"), 0, t);

        // SME never answers: timeout, then owner is gone
        mute = 1;
        job(0, 1, s2q("bc"), 0, t);
        chk("timeout_latency", rsp_cyc - last_strobe_cyc, TIMEOUT + 1);
        mute = 0;
        job(0, 1, s2q("ab"), 0, t);

        // reset in the middle of a string burst
        q = s2q("mnopqrstuvwxyzabcdef");
        predict(1, 0, q, 0);
        drive_seg(1, 0, q, 0, t, ok);
        t2 = 0;
        while (!sme_isstring && t2 < 100) begin
            @(negedge clk);
            t2++;
        end
        chk("reset_test_burst_seen", int'(sme_isstring), 1);
        repeat (3) @(negedge clk);
        reset = 1;
        reset_gen++;
        exp_rsp.delete();
        exp_blen.delete();
        exp_bkind.delete();
        exp_bdata.delete();
        m_owner = -1;
        m_rr = 0;
        @(posedge clk);
        #1;
        chk("midreset_strobes", int'({sme_isstring, sme_ispattern}), 0);
        chk("midreset_rsp_valid", int'(rsp_valid), 0);
        @(negedge clk);
        reset = 0;
        repeat (2) @(negedge clk);
        job(1, 1, s2q("mn"), 0, t);
        job(1, 0, s2q("qrstuv"), 0, t);
        chk("post_reset_str_latency", rsp_cyc - t, 6 + 2);
        job(1, 1, s2q("tu"), 0, t);

        // randomised jobs
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, NREQ - 1);
            kind = ($urandom_range(0, 9) < 4) ? 0 : 1;
            q.delete();
            if (kind == 0) begin
                len = ($urandom_range(0, 9) == 0) ? $urandom_range(33, 36) : $urandom_range(1, 32);
                for (int i = 0; i < len; i++) q.push_back(8'(8'h61 + $urandom_range(0, 3)));
            end else begin
                len = ($urandom_range(0, 9) == 0) ? 9 : $urandom_range(1, 8);
                if (m_str.size() > 0 && $urandom_range(0, 1) == 1) begin
                    if (len > m_str.size()) len = m_str.size();
                    pos = $urandom_range(0, m_str.size() - len);
                    for (int i = 0; i < len; i++) q.push_back(m_str[pos + i]);
                end else begin
                    for (int i = 0; i < len; i++) q.push_back(8'(8'h61 + $urandom_range(0, 3)));
                end
            end
            job(r, kind, q, 1, t);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
